pipe_stage_skid: RTL and testbench

Parametrised pipeline stage register with a valid/ready handshake and a 2-entry skid buffer. It replaces hand-written per-stage registers such as the fetch/decode latch with one generic block for any stage boundary. It provides:
- full throughput under backpressure, with no combinational ready path between stages;
- a synchronous flush that turns the stage contents into bubbles;
- saturating stall and flush performance counters.

---
 rtl/pipe_stage_skid.sv | 122 ++++++++++++
 tb/tb_pipe_stage_skid.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Generic valid/ready pipeline stage with a two-entry skid (main + skid registers).
// Latency: 1 cycle in_data -> out_data when empty, or when holding one payload that drains.
// Backpressure: in_ready is a flop (low only while both entries are full); flush empties the stage.
module pipe_stage_skid #(
  parameter int               WIDTH     = 64,
  parameter logic [WIDTH-1:0] NOP_VALUE = {WIDTH{1'b0}},
  parameter int               CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  input  logic                 flush,
  output logic [1:0]           occupancy,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  occ_e             state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             valid_q;
  logic             ready_q;
  logic             in_fire;
  logic             out_fire;
  logic             stall_inc;
  logic             flush_inc;

  assign in_fire   = in_valid & ready_q;
  assign out_fire  = valid_q & out_ready;
  assign stall_inc = valid_q & ~out_ready;
  assign flush_inc = flush & (state_q != EMPTY);

  assign in_ready  = ready_q;
  assign out_valid = valid_q;
  assign out_data  = main_q;
  assign occupancy = state_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = NOP_VALUE;
      skid_d  = NOP_VALUE;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_d  = in_data;
            state_d = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (out_fire) begin
            main_d  = NOP_VALUE;
            state_d = EMPTY;
          end else if (in_fire) begin
            skid_d  = in_data;
            state_d = TWO;
          end
        end
        TWO: begin
          // in_ready is low here, so only the drain into main can happen
          if (out_fire) begin
            main_d  = skid_q;
            skid_d  = NOP_VALUE;
            state_d = ONE;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = NOP_VALUE;
          skid_d  = NOP_VALUE;
        end
      endcase
    end
  end

  // valid/ready are registered from the next state so neither is combinational
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= NOP_VALUE;
      skid_q  <= NOP_VALUE;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      valid_q <= (state_d != EMPTY);
      ready_q <= (state_d != TWO);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + CNT_WIDTH'(1);
      if (flush_inc && flush_cnt != CNT_MAX) flush_cnt <= flush_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed vector table, hand sequences, and a queue-model random run.
// A second instance with 4-bit counters shares all inputs to exercise saturation.
module tb_pipe_stage_skid;
  localparam int         W   = 16;
  localparam logic [W-1:0] NOP = 16'hDEAD;

  logic          clk = 1'b0;
  logic          reset, in_valid, out_ready, flush;
  logic [W-1:0]  in_data;
  logic          in_ready, out_valid;
  logic [W-1:0]  out_data;
  logic [1:0]    occupancy;
  logic [15:0]   stall_cnt, flush_cnt;
  logic          s_in_ready, s_out_valid;
  logic [W-1:0]  s_out_data;
  logic [1:0]    s_occupancy;
  logic [3:0]    s_stall_cnt, s_flush_cnt;

  always #5 clk = ~clk;

  pipe_stage_skid #(.WIDTH(W), .NOP_VALUE(NOP), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .flush(flush),
    .occupancy(occupancy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  pipe_stage_skid #(.WIDTH(W), .NOP_VALUE(NOP), .CNT_WIDTH(4)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data), .flush(flush),
    .occupancy(s_occupancy), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt));

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic iv, input logic [W-1:0] d, input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  // Reference: the stage is an ordered list of at most two payloads plus two event tallies.
  logic [W-1:0] mq[$];
  int m_stall = 0;
  int m_flush = 0;

  task automatic model_step(input logic iv, input logic [W-1:0] d, input logic ordy, input logic fl);
    bit take, give;
    take = iv && (mq.size() < 2);
    give = (mq.size() > 0) && ordy;
    if (mq.size() > 0 && !ordy) m_stall++;
    if (fl && mq.size() > 0) m_flush++;
    if (fl) mq.delete();
    else begin
      if (give) void'(mq.pop_front());
      if (take) mq.push_back(d);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic check_model(input int cyc);
    chk($sformatf("rnd%0d out_valid", cyc), out_valid, mq.size() > 0);
    chk($sformatf("rnd%0d out_data", cyc), out_data, (mq.size() > 0) ? mq[0] : NOP);
    chk($sformatf("rnd%0d occupancy", cyc), occupancy, mq.size());
    chk($sformatf("rnd%0d in_ready", cyc), in_ready, mq.size() < 2);
    chk($sformatf("rnd%0d stall_cnt", cyc), stall_cnt, sat(m_stall, 65535));
    chk($sformatf("rnd%0d flush_cnt", cyc), flush_cnt, sat(m_flush, 65535));
    chk($sformatf("rnd%0d sat_stall", cyc), s_stall_cnt, sat(m_stall, 15));
    chk($sformatf("rnd%0d sat_flush", cyc), s_flush_cnt, sat(m_flush, 15));
  endtask

  typedef struct {
    logic         iv;
    logic [W-1:0] d;
    logic         ordy;
    logic         fl;
    logic         eov;
    logic [W-1:0] eod;
    logic [1:0]   eocc;
    logic         eir;
    int           estall;
    int           eflush;
  } vec_t;

  vec_t tbl[17];

  initial begin
    // iv, data, out_ready, flush | out_valid, out_data, occupancy, in_ready, stall, flush
    tbl[0]  = '{1'b1, 16'h0001, 1'b1, 1'b0, 1'b1, 16'h0001, 2'd1, 1'b1, 0, 0};
    tbl[1]  = '{1'b1, 16'h0002, 1'b1, 1'b0, 1'b1, 16'h0002, 2'd1, 1'b1, 0, 0};
    tbl[2]  = '{1'b1, 16'h0003, 1'b1, 1'b0, 1'b1, 16'h0003, 2'd1, 1'b1, 0, 0};
    tbl[3]  = '{1'b1, 16'h00A0, 1'b1, 1'b0, 1'b1, 16'h00A0, 2'd1, 1'b1, 0, 0};
    tbl[4]  = '{1'b1, 16'h00B0, 1'b0, 1'b0, 1'b1, 16'h00A0, 2'd2, 1'b0, 1, 0};
    tbl[5]  = '{1'b1, 16'h00C0, 1'b0, 1'b0, 1'b1, 16'h00A0, 2'd2, 1'b0, 2, 0};
    tbl[6]  = '{1'b1, 16'h00C0, 1'b1, 1'b0, 1'b1, 16'h00B0, 2'd1, 1'b1, 2, 0};
    tbl[7]  = '{1'b1, 16'h00C0, 1'b1, 1'b0, 1'b1, 16'h00C0, 2'd1, 1'b1, 2, 0};
    tbl[8]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, NOP,      2'd0, 1'b1, 2, 0};
    tbl[9]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, NOP,      2'd0, 1'b1, 2, 0};
    tbl[10] = '{1'b1, 16'h0011, 1'b0, 1'b0, 1'b1, 16'h0011, 2'd1, 1'b1, 2, 0};
    tbl[11] = '{1'b1, 16'h0022, 1'b0, 1'b0, 1'b1, 16'h0011, 2'd2, 1'b0, 3, 0};
    tbl[12] = '{1'b1, 16'h00D0, 1'b0, 1'b1, 1'b0, NOP,      2'd0, 1'b1, 4, 1};
    tbl[13] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, NOP,      2'd0, 1'b1, 4, 1};
    tbl[14] = '{1'b1, 16'h0044, 1'b1, 1'b1, 1'b0, NOP,      2'd0, 1'b1, 4, 1};
    tbl[15] = '{1'b1, 16'h0055, 1'b1, 1'b0, 1'b1, 16'h0055, 2'd1, 1'b1, 4, 1};
    tbl[16] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, NOP,      2'd0, 1'b1, 4, 1};

    reset = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("reset out_valid", out_valid, 1'b0);
    chk("reset out_data", out_data, NOP);
    chk("reset occupancy", occupancy, 2'd0);
    chk("reset in_ready", in_ready, 1'b1);
    chk("reset stall_cnt", stall_cnt, 0);
    chk("reset flush_cnt", flush_cnt, 0);
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      step(tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].fl);
      chk($sformatf("row%0d out_valid", i), out_valid, tbl[i].eov);
      chk($sformatf("row%0d out_data", i), out_data, tbl[i].eod);
      chk($sformatf("row%0d occupancy", i), occupancy, tbl[i].eocc);
      chk($sformatf("row%0d in_ready", i), in_ready, tbl[i].eir);
      chk($sformatf("row%0d stall_cnt", i), stall_cnt, tbl[i].estall);
      chk($sformatf("row%0d flush_cnt", i), flush_cnt, tbl[i].eflush);
    end

    // Streaming 1..10 at full rate
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, W'(i), 1'b1, 1'b0);
      chk($sformatf("stream%0d out_data", i), out_data, i);
      chk($sformatf("stream%0d occupancy", i), occupancy, 2'd1);
      chk($sformatf("stream%0d in_ready", i), in_ready, 1'b1);
    end
    chk("stream stall_cnt", stall_cnt, 4);
    step(1'b0, '0, 1'b1, 1'b0);

    // Reset mid-stream with both entries full and counters nonzero
    step(1'b1, 16'h0077, 1'b0, 1'b0);
    step(1'b1, 16'h0088, 1'b0, 1'b0);
    chk("pre-reset occupancy", occupancy, 2'd2);
    reset = 1'b1;
    step(1'b1, 16'h0099, 1'b1, 1'b0);
    reset = 1'b0;
    chk("midreset out_valid", out_valid, 1'b0);
    chk("midreset out_data", out_data, NOP);
    chk("midreset occupancy", occupancy, 2'd0);
    chk("midreset in_ready", in_ready, 1'b1);
    chk("midreset stall_cnt", stall_cnt, 0);
    chk("midreset flush_cnt", flush_cnt, 0);
    step(1'b1, 16'h00AB, 1'b1, 1'b0);
    chk("post-reset out_valid", out_valid, 1'b1);
    chk("post-reset out_data", out_data, 16'h00AB);
    step(1'b0, '0, 1'b1, 1'b0);

    // Saturation: 20 stalled cycles against 4-bit and 16-bit counters
    reset = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0);
    reset = 1'b0;
    step(1'b1, 16'h005A, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b0, 1'b0);
    chk("sat stall_cnt 4b", s_stall_cnt, 4'd15);
    chk("sat stall_cnt 16b", stall_cnt, 20);
    chk("sat out_data held", out_data, 16'h005A);

    // Random run against the queue model
    reset = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0);
    reset = 1'b0;
    mq.delete();
    m_stall = 0;
    m_flush = 0;
    for (int c = 0; c < 10000; c++) begin
      logic iv, ordy, fl;
      logic [W-1:0] d;
      iv   = ($urandom_range(0, 99) < 60);
      ordy = ($urandom_range(0, 99) < 55);
      fl   = ($urandom_range(0, 99) < 5);
      d    = W'($urandom);
      model_step(iv, d, ordy, fl);
      step(iv, d, ordy, fl);
      check_model(c);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
